alu_multiciclo: RTL and testbench
=================================

# alu_multiciclo

Parametrised multi-cycle ALU, successor to the 3-bit combinational add/sub/mult unit.
- Performs add, subtract, multiply and divide on two WIDTH-bit unsigned operands.
- Uses a start/busy/done handshake: multiply is iterative shift-add, divide is restoring division, both one bit per clock.
- Registered result feeds the board's BCD / seven-segment display path.
- Adds sign, divide-by-zero flags and remainder output, which the previous unit lacked.

## Interface
- WIDTH, 3, operand width in bits; legal range 2..16.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- portA  in  WIDTH  operand A, unsigned.
- portB  in  WIDTH  operand B, unsigned.
- opcode  in  2  00 add, 01 subtract, 10 multiply, 11 divide.
- start  in  1  operation request, sampled only in IDLE.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result and flags update.
- result  out  2*WIDTH  registered result, zero-extended where narrower.
- neg  out  1  subtract result is negative (result holds magnitude).
- dz  out  1  divide by zero occurred.

## Operation
- States: IDLE, CALC.
  - IDLE with start=1: latch portA, portB, opcode into internal registers; clear iteration counter; go to CALC; busy=1.
  - CALC: execute the latched opcode. On the final step, register result, neg and dz, pulse done, return to IDLE.
- Operand and opcode changes after the start edge have no effect on the running operation.
- Add: result = A + B, WIDTH+1 significant bits. Single CALC cycle. neg=0, dz=0.
- Subtract: if A >= B then result = A - B, neg=0; else result = B - A, neg=1. Single CALC cycle. dz=0.
- Multiply: shift-add over WIDTH CALC cycles.
  - Each cycle: if multiplier LSB = 1, add multiplicand to the partial product; shift.
  - result = A * B, full 2*WIDTH bits. neg=0, dz=0.
- Divide, B != 0: restoring division over WIDTH CALC cycles, MSB first.
  - result[WIDTH-1:0] = quotient A / B.
  - result[2*WIDTH-1:WIDTH] = remainder A % B.
  - neg=0, dz=0.
- Divide, B = 0: single CALC cycle.
  - Quotient field all ones; remainder field = A; dz=1; neg=0.
- result, neg and dz hold their value until the next done; they are not cleared on start.
- start while busy=1 is ignored; it is not queued.
- Reset (rst=0 at a rising edge), including mid-operation:
  - state IDLE, busy=0, done=0, result=0, neg=0, dz=0, counter=0.
  - An aborted operation never produces done.
- Iteration counter is $clog2(WIDTH+1) bits and never wraps within one operation.

## Timing
- Start accepted at edge k. Then busy=1 from after edge k until the edge that asserts done.
- Add, subtract, divide-by-zero: result/flags/done registered at edge k+1.
- Multiply, divide (B != 0): result/flags/done registered at edge k+WIDTH.
- done is high for exactly one cycle. busy=0 in that cycle, since the state is IDLE.
- Back-to-back operation: start=1 during the done cycle is accepted at the next edge; no dead cycle.
- Outputs are purely registered; no combinational path from inputs to outputs.

## Test plan
- Reset then idle, WIDTH=3:
  - rst=0 for 2 cycles.
  - Then result=0, busy=0, done=0, neg=0, dz=0.
  - start held 0: no change for 10 cycles.
- Add and subtract, WIDTH=3:
  - A=7, B=7, op=00: at edge k+1 result=14, done pulse 1 cycle.
  - A=2, B=5, op=01: at k+1 result=3, neg=1.
  - A=5, B=2, op=01: result=3, neg=0.
- Multiply, WIDTH=3:
  - A=7, B=7, op=10: busy 3 cycles, then at edge k+3 result=49, done=1.
  - Toggling portA during CALC leaves result=49.
- Divide, WIDTH=3:
  - A=7, B=2: at k+3 result=6'b001_011 (11), dz=0.
  - A=5, B=0: at k+1 result=6'b101_111 (47), dz=1.
- Handshake edges, WIDTH=3:
  - start pulse during busy of a multiply is ignored; exactly one done.
  - start asserted in the done cycle launches the next op with no gap.
- Reset mid-operation and WIDTH=8:
  - rst=0 at cycle 2 of a multiply: no done; result=0.
  - WIDTH=8: A=255, B=255, op=10 gives result=65025 at k+8.
  - WIDTH=8: A=200, B=7, op=11 gives quotient 28, remainder 4.

Source files
------------

// File: rtl/alu_multiciclo.sv
// ============================================================================
// Module   : alu_multiciclo
// Function : Multi-cycle unsigned ALU (add/sub/shift-add mul/restoring div)
//            with start/busy/done handshake and registered result and flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_multiciclo #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   portA,
  input  logic [WIDTH-1:0]   portB,
  input  logic [1:0]         opcode,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               neg,
  output logic               dz
);

  localparam int               RW        = 2 * WIDTH;
  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [1:0]       OP_ADD    = 2'b00;
  localparam logic [1:0]       OP_SUB    = 2'b01;
  localparam logic [1:0]       OP_MUL    = 2'b10;
  localparam logic [1:0]       OP_DIV    = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // r_a doubles as the dividend/quotient shift register during divide,
  // r_b as the multiplier shift register during multiply.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [RW-1:0]    r_acc;
  logic [RW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_rem;
  logic [RW-1:0]    r_result;
  logic             r_neg;
  logic             r_dz;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [RW-1:0]    w_acc_next;
  logic             w_last;
  logic             w_finish;
  logic [RW-1:0]    w_fin_result;
  logic             w_fin_neg;
  logic             w_fin_dz;

  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_acc_next = r_b[0] ? (r_acc + r_mcand) : r_acc;
  assign w_trial    = {r_rem, r_a[WIDTH-1]} - {1'b0, r_b};
  assign w_fits     = ~w_trial[WIDTH];
  assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_a[WIDTH-1]};
  assign w_quo_next = {r_a[WIDTH-2:0], w_fits};
  assign w_last     = (r_cnt == LAST_STEP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    w_fin_result = r_result;
    w_fin_neg    = 1'b0;
    w_fin_dz     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        case (r_op)
          OP_ADD: begin
            w_finish     = 1'b1;
            w_fin_result = RW'(w_sum);
          end
          OP_SUB: begin
            w_finish = 1'b1;
            if (r_a >= r_b) begin
              w_fin_result = RW'(r_a - r_b);
            end else begin
              w_fin_result = RW'(r_b - r_a);
              w_fin_neg    = 1'b1;
            end
          end
          OP_MUL: begin
            if (w_last) begin
              w_finish     = 1'b1;
              w_fin_result = w_acc_next;
            end
          end
          default: begin
            if (r_b == '0) begin
              w_finish     = 1'b1;
              w_fin_result = {r_a, {WIDTH{1'b1}}};
              w_fin_dz     = 1'b1;
            end else if (w_last) begin
              w_finish     = 1'b1;
              w_fin_result = {w_rem_next, w_quo_next};
            end
          end
        endcase
        if (w_finish) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_result <= w_fin_result;
        r_neg    <= w_fin_neg;
        r_dz     <= w_fin_dz;
      end
      if (r_state == S_IDLE && start) begin
        r_a     <= portA;
        r_b     <= portB;
        r_op    <= opcode;
        r_cnt   <= '0;
        r_acc   <= '0;
        r_mcand <= RW'(portA);
        r_rem   <= '0;
      end else if (r_state == S_CALC && !w_finish) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_op == OP_MUL) begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
        end else if (r_op == OP_DIV) begin
          r_rem <= w_rem_next;
          r_a   <= w_quo_next;
        end
      end
    end
  end

  assign busy   = (r_state == S_CALC);
  assign done   = r_done;
  assign result = r_result;
  assign neg    = r_neg;
  assign dz     = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_alu_multiciclo.sv
// ============================================================================
// Module   : tb_alu_multiciclo
// Function : Self-checking bench for alu_multiciclo at WIDTH=3 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_multiciclo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic [1:0] opcode = '0;
  logic       st3 = 1'b0;
  logic       st8 = 1'b0;

  logic        busy3, done3, neg3, dz3;
  logic [5:0]  res3;
  logic        busy8, done8, neg8, dz8;
  logic [15:0] res8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multiciclo #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .portA(a8[2:0]), .portB(b8[2:0]), .opcode(opcode),
    .start(st3), .busy(busy3), .done(done3), .result(res3), .neg(neg3), .dz(dz3)
  );

  alu_multiciclo #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .portA(a8), .portB(b8), .opcode(opcode),
    .start(st8), .busy(busy8), .done(done8), .result(res8), .neg(neg8), .dz(dz8)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: arithmetic straight from the operation rules.
  function automatic void model(input int w, input int op, input int a, input int b,
                                output int r, output int ng, output int z, output int lat);
    ng = 0; z = 0; lat = 1;
    case (op)
      0: r = a + b;
      1: begin
        if (a >= b) r = a - b;
        else begin r = b - a; ng = 1; end
      end
      2: begin r = a * b; lat = w; end
      default: begin
        if (b == 0) begin
          r = (a << w) | ((1 << w) - 1);
          z = 1;
        end else begin
          r = ((a % b) << w) | (a / b);
          lat = w;
        end
      end
    endcase
  endfunction

  task automatic sample(input int w, output int r, output int bsy, output int dn,
                        output int ng, output int z);
    if (w == 3) begin
      r = int'(res3); bsy = int'(busy3); dn = int'(done3); ng = int'(neg3); z = int'(dz3);
    end else begin
      r = int'(res8); bsy = int'(busy8); dn = int'(done8); ng = int'(neg8); z = int'(dz8);
    end
  endtask

  // Launches one operation; returns in the done cycle so that the next call
  // exercises back-to-back acceptance. Inputs are scrambled while busy.
  task automatic run(input int w, input int op, input int a, input int b);
    int er, eng, edz, elat, r, bsy, dn, ng, z, n;
    bit seen;
    model(w, op, a, b, er, eng, edz, elat);
    opcode = op[1:0];
    a8     = a[7:0];
    b8     = b[7:0];
    if (w == 3) st3 = 1'b1;
    else        st8 = 1'b1;
    @(posedge clk); #1;
    st3 = 1'b0;
    st8 = 1'b0;
    sample(w, r, bsy, dn, ng, z);
    chk("busy_after_start", bsy, 1);
    chk("done_single_pulse", dn, 0);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      opcode = 2'($urandom);
      @(posedge clk); #1;
      n++;
      sample(w, r, bsy, dn, ng, z);
      if (dn != 0) seen = 1'b1;
    end
    chk("done_timeout", int'(seen), 1);
    if (seen) begin
      chk("latency", n, elat);
      chk("result", r, er);
      chk("neg", ng, eng);
      chk("dz", z, edz);
      chk("busy_in_done", bsy, 0);
    end
  endtask

  initial begin
    int cnt, bad, r, bsy, dn, ng, z;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    for (int w = 3; w <= 8; w += 5) begin
      sample(w, r, bsy, dn, ng, z);
      chk("rst_result", r, 0);
      chk("rst_flags", bsy + dn + ng + z, 0);
    end
    rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy3 || done3 || res3 != 0 || busy8 || done8 || res8 != 0) bad++;
    end
    chk("idle_stable", bad, 0);

    // Directed cases
    run(3, 0, 7, 7);
    run(3, 1, 2, 5);
    run(3, 1, 5, 2);
    run(3, 2, 7, 7);
    run(3, 3, 7, 2);
    run(3, 3, 5, 0);
    run(8, 2, 255, 255);
    run(8, 3, 200, 7);

    // Start while busy is ignored
    @(posedge clk); #1;
    opcode = 2'b10; a8 = 8'd7; b8 = 8'd7; st3 = 1'b1;
    @(posedge clk); #1;
    st3 = 1'b0;
    @(posedge clk); #1;
    opcode = 2'b00; a8 = 8'd1; b8 = 8'd1; st3 = 1'b1;
    @(posedge clk); #1;
    st3 = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done3) cnt++;
    end
    chk("ignored_start_dones", cnt, 1);
    chk("ignored_start_result", int'(res3), 49);

    // Reset in the middle of a multiply on both instances
    opcode = 2'b10; a8 = 8'd6; b8 = 8'd5; st3 = 1'b1; st8 = 1'b1;
    @(posedge clk); #1;
    st3 = 1'b0; st8 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("abort_result3", int'(res3), 0);
    chk("abort_result8", int'(res8), 0);
    chk("abort_busy", int'(busy3) + int'(busy8), 0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done3 || done8) cnt++;
    end
    chk("abort_no_done", cnt, 0);

    // Randomized operations, alternating widths
    for (int i = 0; i < 40; i++) begin
      int w, op, a, b;
      w  = (i % 2 == 1) ? 8 : 3;
      op = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, (1 << w) - 1));
      b  = int'($urandom_range(0, (1 << w) - 1));
      if ($urandom_range(0, 4) == 0) b = 0;
      run(w, op, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
